// File: rtl/filter_seq.sv
// filter_seq: frame sequencer for the 3x3 stream filter. Programs the filter cfg bus, streams one
// frame of pixels, then counts results until done. Define FILTER_SEQ_WD_EN for the drain watchdog.
module filter_seq #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int MEM_AWIDTH = 16,
    parameter int IMG_WIDTH  = 16,
    parameter int KER_WIDTH  = 16,
    parameter int CNT_WIDTH  = 24,
    parameter int CFG_GAP    = 4,
    parameter int WD_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            kw_addr,
    input  logic [KER_WIDTH-1:0]  kw_data,
    input  logic                  kw_val,
    input  logic                  start,
    input  logic [MEM_AWIDTH-1:0] frm_width,
    input  logic [CNT_WIDTH-1:0]  frm_pixels,
    input  logic [CNT_WIDTH-1:0]  res_expect,
    input  logic [7:0]            rs_shift,
    input  logic [7:0]            rs_head,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [IMG_WIDTH-1:0]  up_data,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic                  cfg_valid,
    output logic [IMG_WIDTH-1:0]  image,
    output logic                  image_val,
    input  logic                  result_val
);

    localparam int GAP_W = $clog2(CFG_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_W, S_CFG_K, S_CFG_R, S_GAP, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [KER_WIDTH-1:0]  r_tap [0:8];
    logic [MEM_AWIDTH-1:0] r_frm_width;
    logic [CNT_WIDTH-1:0]  r_frm_pixels;
    logic [CNT_WIDTH-1:0]  r_res_expect;
    logic [7:0]            r_rs_shift;
    logic [7:0]            r_rs_head;
    logic [3:0]            r_k_idx;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [CNT_WIDTH-1:0]  r_pix_cnt;
    logic [CNT_WIDTH-1:0]  r_res_cnt;
    logic [IMG_WIDTH-1:0]  r_image_p1;
    logic                  r_image_vld_p1;

    logic w_start_ok;
    logic w_accept;
    logic w_last_pix;
    logic w_res_done;
    logic w_wd_expire;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_accept   = (r_state == S_RUN) && up_val;
    assign w_last_pix = w_accept && (r_pix_cnt == r_frm_pixels - CNT_WIDTH'(1));
    assign w_res_done = (r_res_cnt == r_res_expect);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        up_rdy    = (r_state == S_RUN);
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CFG_W;
            S_CFG_W: begin
                cfg_valid = 1'b1;
                cfg_addr  = CFG_AWIDTH'(1);
                cfg_data  = CFG_DWIDTH'(r_frm_width);
                w_next    = S_CFG_K;
            end
            S_CFG_K: begin
                cfg_valid = 1'b1;
                cfg_addr  = CFG_AWIDTH'(2);
                cfg_data  = CFG_DWIDTH'(r_tap[r_k_idx]);
                if (r_k_idx == 4'd8) w_next = S_CFG_R;
            end
            S_CFG_R: begin
                cfg_valid = 1'b1;
                cfg_addr  = CFG_AWIDTH'(3);
                cfg_data  = CFG_DWIDTH'({r_rs_shift, r_rs_head});
                w_next    = S_GAP;
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_W'(CFG_GAP - 1))
                    w_next = (r_frm_pixels == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN:   if (w_last_pix) w_next = S_DRAIN;
            S_DRAIN: if (w_res_done || w_wd_expire) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Frame fields, taps and sequencing counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_tap[i] <= '0;
            r_frm_width  <= '0;
            r_frm_pixels <= '0;
            r_res_expect <= '0;
            r_rs_shift   <= '0;
            r_rs_head    <= '0;
            r_k_idx      <= '0;
            r_gap_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_res_cnt    <= '0;
        end else begin
            if (w_start_ok) begin
                r_frm_width  <= frm_width;
                r_frm_pixels <= frm_pixels;
                r_res_expect <= res_expect;
                r_rs_shift   <= rs_shift;
                r_rs_head    <= rs_head;
                r_pix_cnt    <= '0;
                r_res_cnt    <= '0;
            end else if ((r_state == S_IDLE) && kw_val && (kw_addr <= 4'd8)) begin
                r_tap[kw_addr] <= kw_data;
            end
            r_k_idx   <= (r_state == S_CFG_K) ? r_k_idx + 4'd1 : 4'd0;
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
            if (w_accept) r_pix_cnt <= r_pix_cnt + CNT_WIDTH'(1);
            // Stops at res_expect so late extra strobes cannot push past the target
            if ((r_state != S_IDLE) && result_val && !w_res_done)
                r_res_cnt <= r_res_cnt + CNT_WIDTH'(1);
        end
    end

    // p1: accepted pixel registered towards the filter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_image_vld_p1 <= 1'b0;
            r_image_p1     <= '0;
        end else begin
            r_image_vld_p1 <= w_accept;
            if (w_accept) r_image_p1 <= up_data;
        end
    end

    assign image     = r_image_p1;
    assign image_val = r_image_vld_p1;

`ifdef FILTER_SEQ_WD_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    assign w_wd_expire = (r_state == S_DRAIN) && !result_val && !w_res_done &&
                         (r_wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_start_ok)       r_err <= 1'b0;
            else if (w_wd_expire) r_err <= 1'b1;
            if ((r_state != S_DRAIN) || result_val) r_wd_cnt <= '0;
            else                                    r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign err = r_err;
`else
    logic w_unused_wd;
    assign w_unused_wd = (WD_CYCLES == 0);
    assign w_wd_expire = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_filter_seq.sv
// Directed bench for filter_seq: cfg sequence, frame streaming, result counting, mid-frame
// ignore, reset abort and (with FILTER_SEQ_WD_EN) the drain watchdog.
`timescale 1ns/1ps
module tb_filter_seq;

    localparam int CFG_DWIDTH = 32;
    localparam int CFG_AWIDTH = 5;
    localparam int MEM_AWIDTH = 16;
    localparam int IMG_WIDTH  = 16;
    localparam int KER_WIDTH  = 16;
    localparam int CNT_WIDTH  = 24;
    localparam int CFG_GAP    = 4;
    localparam int WD_CYCLES  = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [3:0]            kw_addr = '0;
    logic [KER_WIDTH-1:0]  kw_data = '0;
    logic                  kw_val = 1'b0;
    logic                  start = 1'b0;
    logic [MEM_AWIDTH-1:0] frm_width = '0;
    logic [CNT_WIDTH-1:0]  frm_pixels = '0;
    logic [CNT_WIDTH-1:0]  res_expect = '0;
    logic [7:0]            rs_shift = '0;
    logic [7:0]            rs_head = '0;
    logic                  busy, done, err, up_rdy, cfg_valid, image_val;
    logic [IMG_WIDTH-1:0]  up_data;
    logic                  up_val = 1'b0;
    logic [CFG_DWIDTH-1:0] cfg_data;
    logic [CFG_AWIDTH-1:0] cfg_addr;
    logic [IMG_WIDTH-1:0]  image;
    logic                  result_val = 1'b0;

    filter_seq #(
        .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .MEM_AWIDTH(MEM_AWIDTH),
        .IMG_WIDTH(IMG_WIDTH), .KER_WIDTH(KER_WIDTH), .CNT_WIDTH(CNT_WIDTH),
        .CFG_GAP(CFG_GAP), .WD_CYCLES(WD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .kw_addr(kw_addr), .kw_data(kw_data), .kw_val(kw_val),
        .start(start), .frm_width(frm_width), .frm_pixels(frm_pixels),
        .res_expect(res_expect), .rs_shift(rs_shift), .rs_head(rs_head),
        .busy(busy), .done(done), .err(err), .up_data(up_data), .up_val(up_val),
        .up_rdy(up_rdy), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .image(image), .image_val(image_val), .result_val(result_val)
    );

    always #5 clk = ~clk;

    int px_idx = 0;
    always @(posedge clk) if (up_val && up_rdy) px_idx <= px_idx + 1;
    assign up_data = 16'h1000 + px_idx[15:0];

    int          cyc = 0;
    int          cfg_a[$];
    logic [31:0] cfg_d[$];
    int          cfg_c[$];
    logic [15:0] img_v[$];
    int          img_c[$];
    int          acc_c[$];
    int          done_c[$];
    int          both_hi = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cfg_valid) begin
            cfg_a.push_back(int'(cfg_addr));
            cfg_d.push_back(cfg_data);
            cfg_c.push_back(cyc);
        end
        if (image_val) begin
            img_v.push_back(image);
            img_c.push_back(cyc);
        end
        if (up_val && up_rdy) acc_c.push_back(cyc);
        if (done) done_c.push_back(cyc);
        if (cfg_valid && image_val) both_hi++;
    end

    int n_cmp = 0;
    int n_err = 0;
    int base  = 0;
    logic [15:0] exp_tap [0:8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        cfg_a.delete(); cfg_d.delete(); cfg_c.delete();
        img_v.delete(); img_c.delete(); acc_c.delete(); done_c.delete();
        base = px_idx;
    endtask

    task automatic start_frame(input int w, input int pix, input int res,
                               input logic [7:0] sh, input logic [7:0] hd);
        clear_log();
        frm_width  = MEM_AWIDTH'(w);
        frm_pixels = CNT_WIDTH'(pix);
        res_expect = CNT_WIDTH'(res);
        rs_shift   = sh;
        rs_head    = hd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (done_c.size() == 0 && n < lim) begin
            tick();
            n++;
        end
        chk("done_seen", done_c.size() != 0, 1);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic drive_results(input int n, input int spacing);
        for (int i = 0; i < n; i++) begin
            result_val = 1'b1;
            tick();
            result_val = 1'b0;
            repeat (spacing - 1) tick();
        end
    endtask

    task automatic check_cfg(input int w, input logic [7:0] sh, input logic [7:0] hd);
        chk("cfg_count", cfg_c.size(), 11);
        if (cfg_c.size() == 11) begin
            chk("cfg_w_addr", cfg_a[0], 1);
            chk("cfg_w_data", cfg_d[0], w);
            for (int i = 1; i <= 9; i++) begin
                chk($sformatf("cfg_k%0d_addr", i - 1), cfg_a[i], 2);
                chk($sformatf("cfg_k%0d_data", i - 1), cfg_d[i], exp_tap[i-1]);
            end
            chk("cfg_r_addr", cfg_a[10], 3);
            chk("cfg_r_data", cfg_d[10], {16'h0, sh, hd});
            chk("cfg_back_to_back", cfg_c[10] - cfg_c[0], 10);
        end
    endtask

    task automatic check_pixels(input int n);
        chk("accept_count", acc_c.size(), n);
        chk("image_count", img_v.size(), n);
        if (img_v.size() == n && acc_c.size() == n && n > 0) begin
            for (int k = 0; k < n; k++) begin
                chk($sformatf("image_%0d", k), img_v[k], 16'h1000 + 16'(base + k));
                chk($sformatf("image_lat_%0d", k), img_c[k] - acc_c[k], 1);
            end
            chk("no_bubbles", acc_c[n-1] - acc_c[0], n - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_up_rdy", up_rdy, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_cfg_addr", cfg_addr, 0);
        chk("rst_cfg_data", cfg_data, 0);
        chk("rst_image_val", image_val, 0);
        chk("rst_image", image, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            kw_addr = 4'(i);
            kw_data = 16'(i + 1);
            kw_val  = 1'b1;
            tick();
            exp_tap[i] = 16'(i + 1);
        end
        kw_addr = 4'd9; kw_data = 16'hDEAD; tick();
        kw_val = 1'b0;

        // Frame 1: 64 pixels, 36 results, junk start/kw_val mid-frame
        up_val = 1'b1;
        start_frame(8, 64, 36, 8'h03, 8'h05);
        chk("busy_after_start", busy, 1);
        fork
            wait_done(400);
            begin
                int n = 0;
                while (!up_rdy && n < 50) begin tick(); n++; end
                chk("run_reached", up_rdy, 1);
                drive_results(36, 2);
            end
            begin
                repeat (20) tick();
                start = 1'b1; frm_width = 16'd3; frm_pixels = 24'd4; res_expect = 24'd2;
                kw_val = 1'b1; kw_addr = 4'd0; kw_data = 16'h0055;
                tick();
                start = 1'b0; kw_val = 1'b0;
            end
        join
        repeat (4) tick();
        chk("f1_done_pulses", done_c.size(), 1);
        chk("f1_up_rdy_low", up_rdy, 0);
        check_cfg(8, 8'h03, 8'h05);
        check_pixels(64);
        if (cfg_c.size() == 11 && acc_c.size() > 0)
            chk("f1_gap", acc_c[0] - cfg_c[10], CFG_GAP + 1);

        // Frame 2: kw_val in start cycle ignored, extra results during cfg ignored
        clear_log();
        frm_width = 16'd5; frm_pixels = 24'd4; res_expect = 24'd3;
        rs_shift = 8'hA0; rs_head = 8'h0B;
        start = 1'b1; kw_val = 1'b1; kw_addr = 4'd1; kw_data = 16'h0099;
        tick();
        start = 1'b0; kw_val = 1'b0;
        drive_results(5, 1);
        wait_done(200);
        repeat (3) tick();
        chk("f2_done_pulses", done_c.size(), 1);
        check_cfg(5, 8'hA0, 8'h0B);
        check_pixels(4);

        // Frame 3: empty frame, zero results expected
        start_frame(12, 0, 0, 8'h11, 8'h22);
        wait_done(100);
        check_cfg(12, 8'h11, 8'h22);
        chk("f3_no_image", img_v.size(), 0);
        if (cfg_c.size() == 11 && done_c.size() > 0)
            chk("f3_done_latency", done_c[0] - cfg_c[10], CFG_GAP + 2);

        // Frame 4: reset during the fifth tap write
        start_frame(8, 64, 36, 8'h03, 8'h05);
        repeat (5) tick();
        chk("k5_addr", cfg_addr, 2);
        chk("k5_data", cfg_data, 5);
        rst = 1'b1;
        tick();
        chk("abort_cfg_valid", cfg_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_up_rdy", up_rdy, 0);
        chk("abort_image_val", image_val, 0);
        rst = 1'b0;
        chk("abort_cfg_writes", cfg_c.size(), 6);

        // Frame 5: taps were cleared by reset
        for (int i = 0; i < 9; i++) exp_tap[i] = 16'h0;
        start_frame(7, 0, 0, 8'h01, 8'h02);
        wait_done(100);
        check_cfg(7, 8'h01, 8'h02);

`ifdef FILTER_SEQ_WD_EN
        start_frame(4, 2, 10, 8'h00, 8'h00);
        drive_results(3, 1);
        wait_done(200);
        chk("wd_err", err, 1);
        if (acc_c.size() == 2 && done_c.size() > 0)
            chk("wd_latency", done_c[0] - acc_c[1], WD_CYCLES + 1);
        repeat (3) tick();
        chk("wd_err_sticky", err, 1);
        start_frame(4, 0, 0, 8'h00, 8'h00);
        chk("wd_err_cleared", err, 0);
        wait_done(100);
        chk("wd_err_clean_frame", err, 0);
`else
        start_frame(4, 2, 10, 8'h00, 8'h00);
        drive_results(3, 1);
        repeat (100) tick();
        chk("drain_waits_busy", busy, 1);
        chk("drain_waits_no_done", done_c.size(), 0);
        chk("drain_err_tied", err, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("drain_reset_busy", busy, 0);
`endif

        chk("cfg_image_exclusive", both_hi, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
